// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing, derived sync windows and port widths for vga_scan_gen.
package vga_timing_pkg;
    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int HS_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int HS_END   = HS_START + DEF_H_SYNC;
    localparam int VS_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int VS_END   = VS_START + DEF_V_SYNC;
    localparam int ADDR_W   = 19;
    localparam int X_W      = 10;
    localparam int Y_W      = 9;
    localparam int VC_W     = 10;
endpackage

// File: rtl/scan_axis_counter.sv
// scan_axis_counter: wrapping scan counter with terminal count, active-region flag and sync-window decode.
module scan_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int W         = X_W,
    parameter int TOTAL     = H_TOTAL,
    parameter int ACTIVE    = DEF_H_ACTIVE,
    parameter int WIN_START = HS_START,
    parameter int WIN_END   = HS_END
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic         o_tc,
    output logic         o_act,
    output logic         o_win
);
    localparam logic [W-1:0] L_LAST = W'(TOTAL - 1);
    localparam logic [W-1:0] L_ACT  = W'(ACTIVE);
    localparam logic [W-1:0] L_WS   = W'(WIN_START);
    localparam logic [W-1:0] L_WE   = W'(WIN_END);
    logic [W-1:0] r_cnt, w_nxt;
    logic r_act, r_win;
    assign o_tc  = (r_cnt == L_LAST);
    assign w_nxt = !i_en ? r_cnt : o_tc ? '0 : r_cnt + 1'b1;
    assign o_cnt = r_cnt;
    assign o_act = r_act;
    assign o_win = r_win;
    // Flags are decoded from the next count so they register on the same edge as the count itself
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_act <= 1'b1;
            r_win <= 1'b0;
        end else begin
            r_cnt <= w_nxt;
            r_act <= (w_nxt < L_ACT);
            r_win <= (w_nxt >= L_WS) && (w_nxt < L_WE);
        end
    end
endmodule

// File: rtl/vga_scan_gen.sv
// vga_scan_gen: raster timing source (scan counters, syncs, display enable, linear pixel address).
// Optional VGA_SCAN_RGB_GATE_EN: registered colour gating, with syncs/in_display delayed one Clk to match.
module vga_scan_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic              Clk,
    input  logic              Reset,
    output logic              pix_ce,
    output logic [X_W-1:0]    CounterX,
    output logic [Y_W-1:0]    CounterY,
    output logic              in_display,
    output logic              hsync,
    output logic              vsync,
    output logic [ADDR_W-1:0] addr,
    output logic              frame_start
`ifdef VGA_SCAN_RGB_GATE_EN
    ,
    input  logic              R_in,
    input  logic              G_in,
    input  logic              B_in,
    output logic              R,
    output logic              G,
    output logic              B
`endif
);
    localparam int HT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [X_W-1:0]   X_LAST   = X_W'(H_ACTIVE - 1);
    localparam logic [VC_W-1:0]  Y_LAST   = VC_W'(V_ACTIVE - 1);
    logic [DIV_W-1:0]  r_div, w_div_nxt;
    logic              r_pix_ce, r_frame_start;
    logic [ADDR_W-1:0] r_addr;
    logic [X_W-1:0]    w_hcnt;
    logic [VC_W-1:0]   w_vcnt;
    logic w_h_tc, w_v_tc, w_h_act, w_v_act, w_h_win, w_v_win, w_disp, w_wrap, w_last_px;
    assign w_div_nxt = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
    // Pixel-clock divider; pix_ce is registered so it is high while the divider sits at its last count
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_div    <= '0;
            r_pix_ce <= 1'b0;
        end else begin
            r_div    <= w_div_nxt;
            r_pix_ce <= (w_div_nxt == DIV_LAST);
        end
    end
    scan_axis_counter #(
        .W(X_W), .TOTAL(HT), .ACTIVE(H_ACTIVE),
        .WIN_START(H_ACTIVE + H_FP), .WIN_END(H_ACTIVE + H_FP + H_SYNC)
    ) u_h (
        .i_clk(Clk), .i_rst_n(Reset), .i_en(r_pix_ce),
        .o_cnt(w_hcnt), .o_tc(w_h_tc), .o_act(w_h_act), .o_win(w_h_win)
    );
    scan_axis_counter #(
        .W(VC_W), .TOTAL(VT), .ACTIVE(V_ACTIVE),
        .WIN_START(V_ACTIVE + V_FP), .WIN_END(V_ACTIVE + V_FP + V_SYNC)
    ) u_v (
        .i_clk(Clk), .i_rst_n(Reset), .i_en(r_pix_ce & w_h_tc),
        .o_cnt(w_vcnt), .o_tc(w_v_tc), .o_act(w_v_act), .o_win(w_v_win)
    );
    assign w_disp    = w_h_act & w_v_act;
    assign w_wrap    = r_pix_ce & w_h_tc & w_v_tc;
    assign w_last_px = (w_hcnt == X_LAST) && (w_vcnt == Y_LAST);
    // Address advances one per active pixel and parks on the last pixel until the frame wraps
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_addr        <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_wrap;
            if (w_wrap)
                r_addr <= '0;
            else if (r_pix_ce && w_disp && !w_last_px)
                r_addr <= r_addr + 1'b1;
        end
    end
    assign pix_ce      = r_pix_ce;
    assign CounterX    = w_hcnt;
    assign CounterY    = w_vcnt[Y_W-1:0];
    assign addr        = r_addr;
    assign frame_start = r_frame_start;
`ifdef VGA_SCAN_RGB_GATE_EN
    logic r_disp_d, r_hs_d, r_vs_d, r_r, r_g, r_b;
    // Colour is gated and registered; syncs take the same one-Clk delay to stay aligned with it
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_disp_d <= 1'b1;
            r_hs_d   <= 1'b1;
            r_vs_d   <= 1'b1;
            r_r      <= 1'b0;
            r_g      <= 1'b0;
            r_b      <= 1'b0;
        end else begin
            r_disp_d <= w_disp;
            r_hs_d   <= ~w_h_win;
            r_vs_d   <= ~w_v_win;
            r_r      <= R_in & w_disp;
            r_g      <= G_in & w_disp;
            r_b      <= B_in & w_disp;
        end
    end
    assign in_display = r_disp_d;
    assign hsync      = r_hs_d;
    assign vsync      = r_vs_d;
    assign R          = r_r;
    assign G          = r_g;
    assign B          = r_b;
`else
    assign in_display = w_disp;
    assign hsync      = ~w_h_win;
    assign vsync      = ~w_v_win;
`endif
endmodule

// File: tb/tb_vga_scan_gen.sv
// tb_vga_scan_gen: random reset pulses on a reduced raster, checked every Clk against a pixel-count model.
module tb_vga_scan_gen;
    import vga_timing_pkg::*;
    localparam int D = 2, HA = 20, HFP = 3, HSW = 5, HBP = 4, VA = 12, VFP = 2, VSW = 2, VBP = 3;
    localparam int HT = HA + HFP + HSW + HBP, VT = VA + VFP + VSW + VBP, FRAME = HT * VT * D;
    logic Clk = 1'b0, Reset = 1'b0;
    logic pix_ce, in_display, hsync, vsync, frame_start;
    logic [X_W-1:0] CounterX;
    logic [Y_W-1:0] CounterY;
    logic [ADDR_W-1:0] addr;
    int compared = 0, mismatched = 0;
    int c = 0, p = 0, pos, ex, ey, eaddr, cyc = 0, last_fs = -1;
    int epce = 0, edisp = 1, ehs = 1, evs = 1, efs = 0, adv, rst_edge;
`ifdef VGA_SCAN_RGB_GATE_EN
    logic R_in = 1'b0, G_in = 1'b0, B_in = 1'b0, R, G, B;
    int d_disp = 1, d_hs = 1, d_vs = 1, er = 0, eg = 0, eb = 0;
`endif
    always #5 Clk = ~Clk;
    vga_scan_gen #(
        .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
    ) dut (
        .Clk(Clk), .Reset(Reset), .pix_ce(pix_ce), .CounterX(CounterX), .CounterY(CounterY),
        .in_display(in_display), .hsync(hsync), .vsync(vsync), .addr(addr), .frame_start(frame_start)
`ifdef VGA_SCAN_RGB_GATE_EN
        , .R_in(R_in), .G_in(G_in), .B_in(B_in), .R(R), .G(G), .B(B)
`endif
    );
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s at cycle %0d: observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask
    // One Clk: advance the reference model across the edge, then compare every output 1 time unit later
    task automatic step();
        @(posedge Clk);
        cyc++;
        rst_edge = (Reset == 1'b0) ? 1 : 0;
`ifdef VGA_SCAN_RGB_GATE_EN
        d_disp = rst_edge ? 1 : edisp;
        d_hs   = rst_edge ? 1 : ehs;
        d_vs   = rst_edge ? 1 : evs;
        er     = rst_edge ? 0 : (R_in & edisp[0]);
        eg     = rst_edge ? 0 : (G_in & edisp[0]);
        eb     = rst_edge ? 0 : (B_in & edisp[0]);
`endif
        if (rst_edge != 0) begin
            c = 0;
            p = 0;
            adv = 0;
        end else begin
            adv = epce;
            p = p + adv;
            c++;
        end
        epce  = (c >= 1 && c % D == D - 1) ? 1 : 0;
        pos   = p % (HT * VT);
        ex    = pos % HT;
        ey    = pos / HT;
        edisp = (ex < HA && ey < VA) ? 1 : 0;
        ehs   = (ex >= HA + HFP && ex < HA + HFP + HSW) ? 0 : 1;
        evs   = (ey >= VA + VFP && ey < VA + VFP + VSW) ? 0 : 1;
        eaddr = (edisp != 0) ? ey * HA + ex : (ey < VA - 1) ? (ey + 1) * HA : HA * VA - 1;
        efs   = (adv != 0 && pos == 0) ? 1 : 0;
        #1;
        check("pix_ce", 32'(pix_ce), epce);
        check("CounterX", 32'(CounterX), ex);
        check("CounterY", 32'(CounterY), ey % 512);
        check("addr", 32'(addr), eaddr);
        check("frame_start", 32'(frame_start), efs);
`ifdef VGA_SCAN_RGB_GATE_EN
        check("in_display_d", 32'(in_display), d_disp);
        check("hsync_d", 32'(hsync), d_hs);
        check("vsync_d", 32'(vsync), d_vs);
        check("R", 32'(R), er);
        check("G", 32'(G), eg);
        check("B", 32'(B), eb);
        R_in = 1'($urandom_range(0, 3) != 0);
        G_in = 1'($urandom_range(0, 1));
        B_in = 1'($urandom_range(0, 1));
`else
        check("in_display", 32'(in_display), edisp);
        check("hsync", 32'(hsync), ehs);
        check("vsync", 32'(vsync), evs);
`endif
        if (rst_edge != 0) last_fs = -1;
        if (frame_start === 1'b1) begin
            if (last_fs >= 0) check("frame_period", cyc - last_fs, FRAME);
            last_fs = cyc;
        end
    endtask
    initial begin
        Reset = 1'b0;
        repeat (5) step();
        Reset = 1'b1;
        repeat (3 * FRAME + 50) step();
        for (int s = 0; s < 6; s++) begin
            Reset = 1'b0;
            repeat ($urandom_range(1, 4)) step();
            Reset = 1'b1;
            repeat ($urandom_range(1, 2 * FRAME)) step();
        end
        Reset = 1'b0;
        step();
        Reset = 1'b1;
        repeat (FRAME + 20) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
